// File: rtl/fsm_seq_pkg.sv
// fsm_seq_pkg
//   Shared definitions for the code-sequence checker and its generator:
//   the code width, the checker state encoding and the next-code law.
//   The generator runs 0,1,2,3,4,5,6,7 and then loops 5 -> 6 -> 7 -> 5.
package fsm_seq_pkg;

   localparam int CODE_W = 3;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_e;

   // Next-code law of the generator, written in the generator's own
   // gate-level form so both ends share exactly one definition.
   function automatic logic [CODE_W-1:0] seq_next(input logic [CODE_W-1:0] c);
      logic [CODE_W-1:0] n;
      n[2] = c[2] | (c[1] & c[0]);
      n[1] = c[1] ^ c[0];
      n[0] = ~c[0] | (c[2] & c[1]);
      return n;
   endfunction

endpackage

// File: rtl/fsm_seq_checker_next.sv
// seq_next_code
//   Combinational next-code predictor: next_o = nxt(code_i).
//   Ports:
//     code_i  [CODE_W]  current code
//     next_o  [CODE_W]  code the generator must produce next
module seq_next_code
   import fsm_seq_pkg::*;
(
   input  logic [CODE_W-1:0] code_i,
   output logic [CODE_W-1:0] next_o
);

   assign next_o = seq_next(code_i);

endmodule

// File: rtl/fsm_seq_checker.sv
// fsm_seq_checker
//   Receive-side checker for the generator's 3-bit code stream. Samples
//   `code` when `valid` is high, locks after LOCK_N consecutive consistent
//   samples (seed included) and flags every transition in lock that breaks
//   the next-code law.
//   Ports:
//     clk        in   single clock, rising edge
//     Re         in   synchronous active-low reset (wins over everything)
//     valid      in   sample strobe; code ignored while low
//     code       in   [3]  observed code
//     expected   out  [3]  prediction for the next valid sample
//     locked     out  high while in LOCKED
//     err        out  one-cycle pulse per mismatch seen in LOCKED
//     err_count  out  [ERR_W] saturating count of err pulses
//     in_loop    out  locked and last accepted code in 5..7
//     dbg_state  out  [2]  current FSM state (HUNT/ACQUIRE/LOCKED)
//   Handshake: a sample is consumed on every rising edge where valid=1;
//   there is no back-pressure, and outputs reflect that sample one cycle
//   later. With valid=0 everything holds except err, which clears.
module fsm_seq_checker
   import fsm_seq_pkg::*;
#(
   parameter int LOCK_N = 4,
   parameter int ERR_W  = 8
) (
   input  logic              clk,
   input  logic              Re,
   input  logic              valid,
   input  logic [CODE_W-1:0] code,
   output logic [CODE_W-1:0] expected,
   output logic              locked,
   output logic              err,
   output logic [ERR_W-1:0]  err_count,
   output logic              in_loop,
   output logic [1:0]        dbg_state
);

   localparam int RUN_W = $clog2(LOCK_N + 1);
   localparam logic [RUN_W-1:0] LOCK_CNT = RUN_W'(LOCK_N);
   localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

   state_e            state_q, state_d;
   logic [CODE_W-1:0] exp_q, exp_d;
   logic [RUN_W-1:0]  run_q, run_d, run_inc;
   logic              locked_q, locked_d;
   logic              err_q, err_d;
   logic [ERR_W-1:0]  cnt_q, cnt_d;
   logic              in_loop_q, in_loop_d;
   logic [CODE_W-1:0] code_nxt;
   logic              match;

   seq_next_code u_next (
      .code_i (code),
      .next_o (code_nxt)
   );

   assign match   = (code == exp_q);
   assign run_inc = run_q + RUN_ONE;

   always_comb begin
      state_d   = state_q;
      exp_d     = exp_q;
      run_d     = run_q;
      locked_d  = locked_q;
      err_d     = 1'b0;
      cnt_d     = cnt_q;
      in_loop_d = in_loop_q;

      if (valid) begin
         // Every accepted sample reseeds the prediction from the observed
         // code, so a single bad sample costs one resync, not a cascade.
         exp_d = code_nxt;
         case (state_q)
            HUNT: begin
               run_d   = RUN_ONE;
               state_d = ACQUIRE;
            end
            ACQUIRE: begin
               if (match) begin
                  run_d = run_inc;
                  if (run_inc == LOCK_CNT) begin
                     state_d  = LOCKED;
                     locked_d = 1'b1;
                  end
               end else begin
                  run_d = RUN_ONE;
               end
            end
            LOCKED: begin
               if (match) begin
                  in_loop_d = (code >= CODE_W'(5));
               end else begin
                  err_d     = 1'b1;
                  if (cnt_q != {ERR_W{1'b1}}) begin
                     cnt_d = cnt_q + ERR_W'(1);
                  end
                  run_d     = RUN_ONE;
                  locked_d  = 1'b0;
                  in_loop_d = 1'b0;
                  state_d   = ACQUIRE;
               end
            end
            default: begin
               state_d = HUNT;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!Re) begin
         state_q   <= HUNT;
         exp_q     <= '0;
         run_q     <= '0;
         locked_q  <= 1'b0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
         in_loop_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         exp_q     <= exp_d;
         run_q     <= run_d;
         locked_q  <= locked_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
         in_loop_q <= in_loop_d;
      end
   end

   assign expected  = exp_q;
   assign locked    = locked_q;
   assign err       = err_q;
   assign err_count = cnt_q;
   assign in_loop   = in_loop_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_fsm_seq_checker.sv
// tb_fsm_seq_checker
//   Drives fsm_seq_checker (LOCK_N=4, ERR_W=8) and a twin with ERR_W=2 from
//   the same stimulus. A behavioural model predicts every cycle's outputs;
//   predictions are queued when a sample is driven and popped after the edge.
module tb_fsm_seq_checker;

   localparam int LOCK_N = 4;
   localparam int OUT_W  = 18;

   logic       clk;
   logic       Re;
   logic       valid;
   logic [2:0] code;

   logic [2:0] expected, expected2;
   logic       locked, locked2;
   logic       err, err2;
   logic [7:0] err_count;
   logic [1:0] err_count2;
   logic       in_loop, in_loop2;
   logic [1:0] dbg_state, dbg_state2;

   fsm_seq_checker #(.LOCK_N(LOCK_N), .ERR_W(8)) dut (
      .clk       (clk),
      .Re        (Re),
      .valid     (valid),
      .code      (code),
      .expected  (expected),
      .locked    (locked),
      .err       (err),
      .err_count (err_count),
      .in_loop   (in_loop),
      .dbg_state (dbg_state)
   );

   fsm_seq_checker #(.LOCK_N(LOCK_N), .ERR_W(2)) dut_w2 (
      .clk       (clk),
      .Re        (Re),
      .valid     (valid),
      .code      (code),
      .expected  (expected2),
      .locked    (locked2),
      .err       (err2),
      .err_count (err_count2),
      .in_loop   (in_loop2),
      .dbg_state (dbg_state2)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Generator sequence as a lookup table: 0->1 ... 6->7, 7->5
   logic [2:0] nxt_tab [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd5};

   // reference model state
   int         m_state = 0;
   logic [2:0] m_exp = '0;
   int         m_run = 0;
   logic       m_locked = 1'b0;
   logic       m_err = 1'b0;
   int         m_cnt = 0;
   logic       m_in_loop = 1'b0;

   logic [OUT_W-1:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_update(input logic rst_n, input logic v, input logic [2:0] c);
      if (!rst_n) begin
         m_state = 0; m_exp = '0; m_run = 0; m_locked = 1'b0;
         m_err = 1'b0; m_cnt = 0; m_in_loop = 1'b0;
      end else begin
         m_err = 1'b0;
         if (v) begin
            case (m_state)
               0: begin
                  m_run = 1;
                  m_state = 1;
               end
               1: begin
                  if (c == m_exp) begin
                     m_run++;
                     if (m_run == LOCK_N) begin
                        m_state = 2;
                        m_locked = 1'b1;
                     end
                  end else begin
                     m_run = 1;
                  end
               end
               default: begin
                  if (c == m_exp) begin
                     m_in_loop = (c >= 3'd5);
                  end else begin
                     m_err = 1'b1;
                     m_cnt++;
                     m_run = 1;
                     m_locked = 1'b0;
                     m_in_loop = 1'b0;
                     m_state = 1;
                  end
               end
            endcase
            m_exp = nxt_tab[c];
         end
      end
   endtask

   // driver: apply one cycle of stimulus, predict, then compare after the edge
   task automatic step(input logic rst_n, input logic v, input logic [2:0] c);
      logic [OUT_W-1:0] e;
      logic [7:0]       c8;
      logic [1:0]       c2;
      @(negedge clk);
      Re    = rst_n;
      valid = v;
      code  = c;
      model_update(rst_n, v, c);
      c8 = (m_cnt > 255) ? 8'hff : 8'(m_cnt);
      c2 = (m_cnt > 3)   ? 2'd3  : 2'(m_cnt);
      exp_q.push_back({m_exp, m_locked, m_err, c8, c2, m_in_loop, 2'(m_state)});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk("queue_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk("expected",    32'(expected),   32'(e[17:15]));
         chk("locked",      32'(locked),     32'(e[14]));
         chk("err",         32'(err),        32'(e[13]));
         chk("err_count",   32'(err_count),  32'(e[12:5]));
         chk("err_count_w2",32'(err_count2), 32'(e[4:3]));
         chk("locked_w2",   32'(locked2),    32'(e[14]));
         chk("in_loop",     32'(in_loop),    32'(e[2]));
         chk("state",       32'(dbg_state),  32'(e[1:0]));
      end
   endtask

   initial begin
      logic [2:0] r;
      Re    = 1'b0;
      valid = 1'b0;
      code  = '0;

      // reset
      step(1'b0, 1'b0, 3'd0);
      step(1'b0, 1'b1, 3'd5);
      chk("reset_expected", 32'(expected), 32'd0);
      chk("reset_locked",   32'(locked),   32'd0);

      // acquire from 0,1,2,3
      step(1'b1, 1'b1, 3'd0);
      step(1'b1, 1'b1, 3'd1);
      step(1'b1, 1'b1, 3'd2);
      chk("not_locked_at_3", 32'(locked), 32'd0);
      step(1'b1, 1'b1, 3'd3);
      chk("locked_at_4",   32'(locked),   32'd1);
      chk("expected_is_4", 32'(expected), 32'd4);

      // through the loop, including the 7 -> 5 wrap
      step(1'b1, 1'b1, 3'd4);
      chk("in_loop_before_5", 32'(in_loop), 32'd0);
      step(1'b1, 1'b1, 3'd5);
      chk("in_loop_at_5", 32'(in_loop), 32'd1);
      step(1'b1, 1'b1, 3'd6);
      step(1'b1, 1'b1, 3'd7);
      step(1'b1, 1'b1, 3'd5);
      chk("wrap_no_err", 32'(err), 32'd0);

      // mismatch: 3 instead of 6, then relock on 4,5,6
      step(1'b1, 1'b1, 3'd3);
      chk("mm_err",      32'(err),       32'd1);
      chk("mm_cnt",      32'(err_count), 32'd1);
      chk("mm_unlocked", 32'(locked),    32'd0);
      chk("mm_expected", 32'(expected),  32'd4);
      step(1'b1, 1'b1, 3'd4);
      chk("err_one_cycle", 32'(err), 32'd0);
      step(1'b1, 1'b1, 3'd5);
      step(1'b1, 1'b1, 3'd6);
      chk("relock", 32'(locked), 32'd1);
      step(1'b1, 1'b1, 3'd7);

      // valid gaps carrying garbage codes
      step(1'b0, 1'b0, 3'd0);
      step(1'b1, 1'b1, 3'd0);
      step(1'b1, 1'b0, 3'd7);
      step(1'b1, 1'b1, 3'd1);
      step(1'b1, 1'b0, 3'd0);
      step(1'b1, 1'b1, 3'd2);
      step(1'b1, 1'b0, 3'd2);
      chk("gap_not_locked", 32'(locked), 32'd0);
      step(1'b1, 1'b1, 3'd3);
      chk("gap_locked", 32'(locked), 32'd1);

      // five mismatches from LOCKED; ERR_W=2 twin saturates at 3
      for (int i = 0; i < 5; i++) begin
         r = 3'($urandom_range(1, 7));
         step(1'b1, 1'b1, m_exp ^ r);
         chk("sat_err_pulse", 32'(err), 32'd1);
         if (i == 2) chk("sat_w2_at_3", 32'(err_count2), 32'd3);
         for (int k = 0; k < 3; k++) step(1'b1, 1'b1, m_exp);
         chk("sat_relocked", 32'(locked), 32'd1);
      end
      chk("sat_w2_held", 32'(err_count2), 32'd3);
      chk("sat_w8_five", 32'(err_count),  32'd5);

      // random stream, mostly legal, with gaps and occasional corruption
      for (int i = 0; i < 60; i++) begin
         r = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : m_exp;
         step(1'b1, ($urandom_range(0, 3) != 0), r);
      end

      // reset while locked with err_count=2
      step(1'b0, 1'b0, 3'd0);
      step(1'b1, 1'b1, 3'd0);
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, m_exp);
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, m_exp ^ 3'd2);
         for (int k = 0; k < 3; k++) step(1'b1, 1'b1, m_exp);
      end
      chk("pre_rst_locked", 32'(locked),    32'd1);
      chk("pre_rst_cnt",    32'(err_count), 32'd2);
      step(1'b0, 1'b1, m_exp);
      chk("rst_locked",   32'(locked),    32'd0);
      chk("rst_cnt",      32'(err_count), 32'd0);
      chk("rst_expected", 32'(expected),  32'd0);
      chk("rst_state",    32'(dbg_state), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fsm_seq_checker.md
# fsm_seq_checker

Receive-side checker for the 3-bit free-running code sequence produced by the team's DFF-based sequence generator. The generator's sequence is 0,1,2,3,4,5,6,7,5,6,7,… with the loop 5→6→7→5. This block samples a 3-bit code stream on a valid strobe, acquires lock after a run of consistent transitions, and flags every transition that breaks the generator's next-state law. It sits at the far end of the code bus, next to the generator's consumer.

## Interface
Parameters:
- LOCK_N, 4: consecutive consistent samples, including the seed sample, required to declare lock; legal range ≥ 2.
- ERR_W, 8: width of the error counter.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- Re  in  1  reset, synchronous, active-low; overrides all other inputs on the edge where it is low.
- valid  in  1  sample strobe; `code` is examined only when valid=1.
- code  in  3  observed code from the generator, {z2,z1,z0}.
- expected  out  3  registered prediction for the next valid sample.
- locked  out  1  registered; 1 while in LOCKED.
- err  out  1  registered one-cycle pulse per mismatch detected in LOCKED.
- err_count  out  ERR_W  registered saturating count of err pulses.
- in_loop  out  1  registered; 1 when locked and the last accepted code is in {5,6,7}.

## Operation
- Next-code law, called nxt(c): n2 = c2 | (c1 & c0); n1 = c1 ^ c0; n0 = ~c0 | (c2 & c1).
- Reset values: state HUNT, expected=0, run_cnt=0, locked=0, err=0, err_count=0, in_loop=0.
- State HUNT, on valid:
  - expected ← nxt(code), run_cnt ← 1, go to ACQUIRE.
- State ACQUIRE, on valid:
  - code==expected: expected ← nxt(code), run_cnt ← run_cnt+1; if run_cnt+1 == LOCK_N, go to LOCKED.
  - code!=expected: expected ← nxt(code), run_cnt ← 1, stay in ACQUIRE. err is not raised.
- State LOCKED, on valid:
  - code==expected: expected ← nxt(code); in_loop ← (code ≥ 5).
  - code!=expected: err ← 1 for one cycle; err_count ← err_count+1, saturating at all-ones; expected ← nxt(code), run_cnt ← 1, locked ← 0, in_loop ← 0; go to ACQUIRE.
- valid=0: all state holds, err ← 0, and `code` is ignored.
- run_cnt width is clog2(LOCK_N+1).
- Wrap: 7→5 is a match. A code in 0..4 arriving after the loop has been entered is a mismatch by the law; no special case is needed.

## Timing
- Latency from a sample on edge k to the updated outputs is one cycle; the outputs are valid after edge k.
- Lock: `locked` rises on the edge that accepts the LOCK_N-th consistent sample.
- Error: `err` is high for exactly the cycle following the mismatching sample's edge; `locked` falls on the same edge.
- Back-to-back mismatches in LOCKED are impossible. The first mismatch exits LOCKED, and further mismatches in ACQUIRE only reseed.
- Reset mid-operation: on any edge with Re=0, all outputs and state return to their reset values on that edge, regardless of valid.
- err_count is held while err_count is all-ones and another mismatch occurs; err still pulses.

## Structure
- Package fsm_seq_pkg contains:
  - CODE_W = 3;
  - the state enum {HUNT, ACQUIRE, LOCKED};
  - the function seq_next implementing nxt().
- Sub-module seq_next_code: combinational nxt(). It is shared with the generator so both ends use one definition of the law.
- All registers live in one clocked process; there are no DFF instances.

## Test plan
All scenarios use LOCK_N=4 and ERR_W=8 unless stated.
- Reset, then valid on every cycle with codes 0,1,2,3 → locked=1 after the 4th edge; expected=4; err=0; err_count=0.
- Continue with 4,5,6,7,5,6,7 → locked stays 1; in_loop=1 from sample 5 onward; err never asserts.
- While locked after 5, drive 3 instead of 6 → err=1 for one cycle; err_count=1; locked=0; expected=4. Then 4,5,6,7 → relock after the 3rd of those samples.
- Interleave valid=0 cycles carrying garbage codes (7,0,2) within a legal stream → no state change; lock is acquired on the same sample count as without gaps.
- ERR_W=2, five forced mismatches, each from LOCKED → err pulses 5 times; err_count=3 after the 3rd and held.
- While locked with err_count=2, drive Re=0 for one edge → the next cycle shows locked=0, err_count=0, expected=0, state HUNT.
